setpoint_edit_controller: RTL and testbench

SETPOINT_EDIT_CONTROLLER -- requirements
Module: setpoint_edit_controller

---
 rtl/setpoint_edit_controller.sv | 180 ++++++++++++++++++
 tb/tb_setpoint_edit_controller.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/setpoint_edit_controller.sv
// Thermostat setpoint editor: MODE/UP/DOWN edit BCD temperature/humidity; idle frames cancel.
// Latency: state/EDIT_SEL/EDIT_BLINK 1 cycle; SET_* refresh on the frame strobe only; no backpressure.
module setpoint_edit_controller #(
  parameter logic [11:0] TEMP_DEFAULT   = 12'h072,
  parameter logic [11:0] TEMP_MIN       = 12'h040,
  parameter logic [11:0] TEMP_MAX       = 12'h100,
  parameter logic [7:0]  HUM_DEFAULT    = 8'h50,
  parameter logic [7:0]  HUM_MIN        = 8'h20,
  parameter logic [7:0]  HUM_MAX        = 8'h90,
  parameter int          TIMEOUT_FRAMES = 600,
  parameter int          BLINK_FRAMES   = 30
) (
  input  logic        CLOCK_50,
  input  logic        RESET_N,
  input  logic        BTN_MODE,
  input  logic        BTN_UP,
  input  logic        BTN_DOWN,
  input  logic        VGA_VS,
  output logic [11:0] SET_TEMP_F,
  output logic [7:0]  SET_HUM,
  output logic [1:0]  EDIT_SEL,
  output logic        EDIT_BLINK
);

  localparam int TW = $clog2(TIMEOUT_FRAMES + 1);
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  localparam logic [TW-1:0] TO_LIM  = TW'(TIMEOUT_FRAMES);
  localparam logic [BW-1:0] BL_LAST = BW'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    EDIT_TEMP = 2'b01,
    EDIT_HUM  = 2'b10
  } state_t;

  state_t        state, state_nxt;
  logic          vs_prev, frame_stb;
  logic [11:0]   wrk_temp, wrk_temp_nxt, com_temp, com_temp_nxt;
  logic [7:0]    wrk_hum, wrk_hum_nxt, com_hum, com_hum_nxt;
  logic [TW-1:0] idle_cnt, idle_cnt_nxt;
  logic [BW-1:0] blink_cnt, blink_cnt_nxt;
  logic          blink_nxt;

  logic          btn_any, step, timeout;
  logic          tc1, tc2, hc1;
  logic [11:0]   temp_step;
  logic [7:0]    hum_step;
  logic          temp_at_lim, hum_at_lim;

  // One BCD digit moved by one when its carry/borrow-in is set.
  function automatic logic [3:0] dig_step(input logic [3:0] d, input logic cin, input logic up);
    if (!cin) return d;
    if (up) return (d == 4'd9) ? 4'd0 : d + 4'd1;
    return (d == 4'd0) ? 4'd9 : d - 4'd1;
  endfunction

  function automatic logic dig_wrap(input logic [3:0] d, input logic up);
    return up ? (d == 4'd9) : (d == 4'd0);
  endfunction

  always_comb begin
    state_nxt     = state;
    wrk_temp_nxt  = wrk_temp;
    wrk_hum_nxt   = wrk_hum;
    com_temp_nxt  = com_temp;
    com_hum_nxt   = com_hum;
    idle_cnt_nxt  = idle_cnt;
    blink_cnt_nxt = blink_cnt;
    blink_nxt     = EDIT_BLINK;

    btn_any = BTN_MODE | BTN_UP | BTN_DOWN;
    step    = BTN_UP ^ BTN_DOWN;
    // Any button pulse beats an expiring idle count.
    timeout = (state != IDLE) && (idle_cnt >= TO_LIM) && !btn_any;

    tc1       = dig_wrap(wrk_temp[3:0], BTN_UP);
    tc2       = tc1 & dig_wrap(wrk_temp[7:4], BTN_UP);
    temp_step = {dig_step(wrk_temp[11:8], tc2, BTN_UP),
                 dig_step(wrk_temp[7:4], tc1, BTN_UP),
                 dig_step(wrk_temp[3:0], 1'b1, BTN_UP)};
    hc1       = dig_wrap(wrk_hum[3:0], BTN_UP);
    hum_step  = {dig_step(wrk_hum[7:4], hc1, BTN_UP),
                 dig_step(wrk_hum[3:0], 1'b1, BTN_UP)};

    // BCD order matches binary order, so plain compares give the limits.
    temp_at_lim = BTN_UP ? (wrk_temp >= TEMP_MAX) : (wrk_temp <= TEMP_MIN);
    hum_at_lim  = BTN_UP ? (wrk_hum >= HUM_MAX) : (wrk_hum <= HUM_MIN);

    case (state)
      IDLE: begin
        if (BTN_MODE) begin
          state_nxt    = EDIT_TEMP;
          wrk_temp_nxt = com_temp;
          wrk_hum_nxt  = com_hum;
        end
      end
      EDIT_TEMP: begin
        if (BTN_MODE) begin
          state_nxt = EDIT_HUM;
        end else if (timeout) begin
          state_nxt    = IDLE;
          wrk_temp_nxt = com_temp;
          wrk_hum_nxt  = com_hum;
        end else if (step && !temp_at_lim) begin
          wrk_temp_nxt = temp_step;
        end
      end
      EDIT_HUM: begin
        if (BTN_MODE) begin
          state_nxt    = IDLE;
          com_temp_nxt = wrk_temp;
          com_hum_nxt  = wrk_hum;
        end else if (timeout) begin
          state_nxt    = IDLE;
          wrk_temp_nxt = com_temp;
          wrk_hum_nxt  = com_hum;
        end else if (step && !hum_at_lim) begin
          wrk_hum_nxt = hum_step;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (state == IDLE || btn_any || timeout) begin
      idle_cnt_nxt = '0;
    end else if (frame_stb) begin
      idle_cnt_nxt = idle_cnt + TW'(1);
    end

    if (state_nxt == IDLE) begin
      blink_cnt_nxt = '0;
      blink_nxt     = 1'b0;
    end else if (state_nxt != state) begin
      blink_cnt_nxt = '0;
      blink_nxt     = 1'b1;
    end else if (frame_stb) begin
      if (blink_cnt == BL_LAST) begin
        blink_cnt_nxt = '0;
        blink_nxt     = ~EDIT_BLINK;
      end else begin
        blink_cnt_nxt = blink_cnt + BW'(1);
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= IDLE;
      vs_prev    <= 1'b1;
      frame_stb  <= 1'b0;
      wrk_temp   <= TEMP_DEFAULT;
      wrk_hum    <= HUM_DEFAULT;
      com_temp   <= TEMP_DEFAULT;
      com_hum    <= HUM_DEFAULT;
      idle_cnt   <= '0;
      blink_cnt  <= '0;
      SET_TEMP_F <= TEMP_DEFAULT;
      SET_HUM    <= HUM_DEFAULT;
      EDIT_SEL   <= 2'b00;
      EDIT_BLINK <= 1'b0;
    end else begin
      state      <= state_nxt;
      vs_prev    <= VGA_VS;
      frame_stb  <= vs_prev & ~VGA_VS;
      wrk_temp   <= wrk_temp_nxt;
      wrk_hum    <= wrk_hum_nxt;
      com_temp   <= com_temp_nxt;
      com_hum    <= com_hum_nxt;
      idle_cnt   <= idle_cnt_nxt;
      blink_cnt  <= blink_cnt_nxt;
      EDIT_SEL   <= state_nxt;
      EDIT_BLINK <= blink_nxt;
      if (frame_stb) begin
        SET_TEMP_F <= wrk_temp;
        SET_HUM    <= wrk_hum;
      end
    end
  end

endmodule

// File: tb/tb_setpoint_edit_controller.sv
// Directed bench for setpoint_edit_controller: button/frame sequences against hand-computed BCD values.
module tb_setpoint_edit_controller;

  logic        CLOCK_50 = 1'b0;
  logic        RESET_N  = 1'b0;
  logic        BTN_MODE = 1'b0;
  logic        BTN_UP   = 1'b0;
  logic        BTN_DOWN = 1'b0;
  logic        VGA_VS   = 1'b1;
  logic [11:0] SET_TEMP_F;
  logic [7:0]  SET_HUM;
  logic [1:0]  EDIT_SEL;
  logic        EDIT_BLINK;

  int n_cmp = 0;
  int n_bad = 0;

  setpoint_edit_controller dut (
    .CLOCK_50  (CLOCK_50),
    .RESET_N   (RESET_N),
    .BTN_MODE  (BTN_MODE),
    .BTN_UP    (BTN_UP),
    .BTN_DOWN  (BTN_DOWN),
    .VGA_VS    (VGA_VS),
    .SET_TEMP_F(SET_TEMP_F),
    .SET_HUM   (SET_HUM),
    .EDIT_SEL  (EDIT_SEL),
    .EDIT_BLINK(EDIT_BLINK)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic m, input logic u, input logic d);
    @(negedge CLOCK_50);
    BTN_MODE = m;
    BTN_UP   = u;
    BTN_DOWN = d;
    @(negedge CLOCK_50);
    BTN_MODE = 1'b0;
    BTN_UP   = 1'b0;
    BTN_DOWN = 1'b0;
  endtask

  task automatic pulses(input logic u, input int n);
    for (int i = 0; i < n; i++) pulse(1'b0, u, ~u);
  endtask

  // VS low for one cycle; the strobe lands after the next edge and outputs load on the one after.
  task automatic frame();
    @(negedge CLOCK_50);
    VGA_VS = 1'b0;
    @(negedge CLOCK_50);
    VGA_VS = 1'b1;
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  // Frame whose timeout-evaluation cycle carries a BTN_UP pulse.
  task automatic frame_with_up();
    @(negedge CLOCK_50);
    VGA_VS = 1'b0;
    @(negedge CLOCK_50);
    VGA_VS = 1'b1;
    @(negedge CLOCK_50);
    BTN_UP = 1'b1;
    @(negedge CLOCK_50);
    BTN_UP = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge CLOCK_50);
    check_val("rst_temp",  32'(SET_TEMP_F), 'h072);
    check_val("rst_hum",   32'(SET_HUM),    'h50);
    check_val("rst_sel",   32'(EDIT_SEL),   'h0);
    check_val("rst_blink", 32'(EDIT_BLINK), 'h0);
    RESET_N = 1'b1;
    frame();
    check_val("rst_frame_temp", 32'(SET_TEMP_F), 'h072);

    // Edit then go idle: 600 idle frames cancel and restore the committed value.
    pulse(1'b1, 1'b0, 1'b0);
    check_val("enter_sel",   32'(EDIT_SEL),   'h1);
    check_val("enter_blink", 32'(EDIT_BLINK), 'h1);
    pulse(1'b0, 1'b1, 1'b0);
    frames(599);
    check_val("to_599_sel", 32'(EDIT_SEL), 'h1);
    frame();
    check_val("to_600_sel",   32'(EDIT_SEL),   'h0);
    check_val("to_600_blink", 32'(EDIT_BLINK), 'h0);
    check_val("to_600_shown", 32'(SET_TEMP_F), 'h073);
    frame();
    check_val("to_restore", 32'(SET_TEMP_F), 'h072);

    // MODE, UP x3, MODE, DOWN x2, MODE, frame.
    pulse(1'b1, 1'b0, 1'b0);
    pulses(1'b1, 3);
    pulse(1'b1, 1'b0, 1'b0);
    check_val("hum_sel",   32'(EDIT_SEL),   'h2);
    check_val("hum_blink", 32'(EDIT_BLINK), 'h1);
    pulses(1'b0, 2);
    pulse(1'b1, 1'b0, 1'b0);
    check_val("commit_sel",      32'(EDIT_SEL),   'h0);
    check_val("commit_preframe", 32'(SET_TEMP_F), 'h072);
    frame();
    check_val("commit_temp", 32'(SET_TEMP_F), 'h075);
    check_val("commit_hum",  32'(SET_HUM),    'h48);

    // Mid-frame UP stays hidden until the strobe after the VS fall.
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    repeat (5) @(negedge CLOCK_50);
    check_val("mid_hold", 32'(SET_TEMP_F), 'h075);
    VGA_VS = 1'b0;
    @(negedge CLOCK_50);
    VGA_VS = 1'b1;
    check_val("mid_strobe_cycle", 32'(SET_TEMP_F), 'h075);
    @(negedge CLOCK_50);
    check_val("mid_loaded", 32'(SET_TEMP_F), 'h076);
    pulse(1'b0, 1'b1, 1'b1);
    frame();
    check_val("updown_nochange", 32'(SET_TEMP_F), 'h076);
    pulse(1'b1, 1'b1, 1'b0);
    check_val("mode_wins_sel", 32'(EDIT_SEL), 'h2);
    frame();
    check_val("mode_wins_temp", 32'(SET_TEMP_F), 'h076);
    check_val("mode_wins_hum",  32'(SET_HUM),    'h48);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    frame();
    check_val("idle_ignores_up", 32'(SET_TEMP_F), 'h076);

    // Carry, saturation and borrow on temperature; floor and blink on humidity.
    pulse(1'b1, 1'b0, 1'b0);
    pulses(1'b1, 23);
    frame();
    check_val("temp_099", 32'(SET_TEMP_F), 'h099);
    pulse(1'b0, 1'b1, 1'b0);
    frame();
    check_val("temp_carry_100", 32'(SET_TEMP_F), 'h100);
    pulse(1'b0, 1'b1, 1'b0);
    frame();
    check_val("temp_sat_max", 32'(SET_TEMP_F), 'h100);
    pulse(1'b0, 1'b0, 1'b1);
    frame();
    check_val("temp_borrow_099", 32'(SET_TEMP_F), 'h099);
    pulse(1'b1, 1'b0, 1'b0);
    frames(29);
    check_val("blink_29", 32'(EDIT_BLINK), 'h1);
    frame();
    check_val("blink_30", 32'(EDIT_BLINK), 'h0);
    pulses(1'b0, 28);
    frame();
    check_val("hum_020", 32'(SET_HUM), 'h20);
    pulse(1'b0, 1'b0, 1'b1);
    frame();
    check_val("hum_sat_min", 32'(SET_HUM), 'h20);
    pulse(1'b1, 1'b0, 1'b0);

    // UP on the very cycle the timeout expires: UP acts, counter restarts from 0.
    pulse(1'b1, 1'b0, 1'b0);
    frames(599);
    frame_with_up();
    check_val("to_race_sel", 32'(EDIT_SEL), 'h1);
    frame();
    check_val("to_race_temp", 32'(SET_TEMP_F), 'h100);
    frames(598);
    check_val("to_race_599", 32'(EDIT_SEL), 'h1);
    frame();
    check_val("to_race_600", 32'(EDIT_SEL), 'h0);
    frame();
    check_val("to_race_restore", 32'(SET_TEMP_F), 'h099);

    // Reset in the middle of a humidity edit.
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    pulses(1'b1, 43);
    frame();
    check_val("pre_rst_hum", 32'(SET_HUM),  'h63);
    check_val("pre_rst_sel", 32'(EDIT_SEL), 'h2);
    @(negedge CLOCK_50);
    #3 RESET_N = 1'b0;
    #1;
    check_val("arst_temp",  32'(SET_TEMP_F), 'h072);
    check_val("arst_hum",   32'(SET_HUM),    'h50);
    check_val("arst_sel",   32'(EDIT_SEL),   'h0);
    check_val("arst_blink", 32'(EDIT_BLINK), 'h0);
    @(negedge CLOCK_50);
    RESET_N = 1'b1;
    frame();
    check_val("post_rst_temp", 32'(SET_TEMP_F), 'h072);
    check_val("post_rst_hum",  32'(SET_HUM),    'h50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
